sisc_ifetch: RTL and testbench
==============================

# sisc_ifetch

Instruction-fetch stage of the SISC computer, sitting directly upstream of the control FSM. It holds the program counter (PC) and instruction register (IR), fetches instructions from instruction memory over a req/ack handshake, and resolves branches. It supplies `opcode`, `mm` and the raw instruction word to the control FSM and datapath.

## Interface
- AW, 16, PC / instruction-memory address width
- DW, 32, instruction width
- RESET_PC, 0, PC value loaded at reset
- clk  input  1  system clock, all state changes on rising edge
- rst_f  input  1  asynchronous, active-low reset
- fetch_go  input  1  single-cycle pulse from ctrl: start a fetch at current PC
- br_en  input  1  single-cycle pulse from ctrl: evaluate branch for the instruction in IR
- stat  input  4  status flags from the status register
- imem_req  output  1  instruction-memory read request, registered
- imem_addr  output  AW  read address, equals PC while imem_req is high
- imem_data  input  DW  read data, valid when imem_ack is high
- imem_ack  input  1  memory completion strobe
- ir  output  DW  instruction register
- opcode  output  4  ir[31:28]
- mm  output  4  ir[27:24]
- pc  output  AW  program counter (address of next instruction to fetch)
- ir_valid  output  1  one-cycle pulse: new instruction latched in IR
- halted  output  1  sticky: HLT (opcode 15) has been latched
- seq_err  output  1  sticky: protocol violation by ctrl

## Operation
- Instruction fields: opcode ir[31:28], mm ir[27:24], imm ir[15:0].
- States: IDLE, REQ, DONE.
- IDLE: fetch_go and not halted -> REQ, imem_req<=1. fetch_go while halted: ignored, no error.
- REQ: imem_req held high, imem_addr=pc. On imem_ack: ir<=imem_data, pc<=pc+1 (mod 2^AW), imem_req<=0 -> DONE.
- DONE: ir_valid high for exactly this cycle; if the latched opcode is 15, halted<=1. -> IDLE.
- Branch (br_en, honoured only in IDLE):
  - BRA (4): taken if mm==0 or (mm & stat)!=0; target = imm.
  - BRR (5): same condition; target = pc + sign_extend(imm), truncated to AW (pc already points past the branch).
  - BNE (6): taken if (mm & stat)==0; target = imm.
  - Any other opcode: no PC change, no error.
  - Taken: pc<=target. Not taken: pc unchanged.
- Same-cycle br_en and fetch_go in IDLE: the branch resolves first. The fetch is issued at the resolved PC, so imem_addr equals the branch target when taken.
- fetch_go or br_en seen in REQ or DONE: ignored and seq_err<=1. The fetch in progress is unaffected.
- imem_ack outside REQ: ignored.
- seq_err and halted clear only on reset.

## Timing
- Reset (async, immediate):
  - pc=RESET_PC, ir=0 (NOOP), so opcode=0 and mm=0.
  - imem_req=0, ir_valid=0, halted=0, seq_err=0, state IDLE.
  - An imem_ack after reset deassertion for a pre-reset request is ignored.
- fetch_go sampled at edge k: imem_req high from k.
- Earliest imem_ack sampled at edge k+1: IR and PC update at k+1; ir_valid high during cycle k+1..k+2; IDLE at k+2.
- Minimum fetch-to-fetch interval is 2 cycles. Each additional wait cycle of imem_ack adds 1.
- The ack-cycle PC increment and a br_en cannot coincide, because br_en is only legal in IDLE.
- pc, ir, opcode and mm are registered and stable except at the edges listed above.

## Test plan
- Reset then fetch: rst_f low then high, fetch_go, imem_ack next cycle with imem_data=0x8123_0000 -> imem_addr=0, opcode=8, mm=1, pc=1, single ir_valid pulse 2 cycles after fetch_go.
- Wait states: ack delayed 3 cycles -> imem_req held high for 4 cycles with imem_addr stable; one ir_valid; pc increments once.
- Branches: IR=0x4000_0040 (BRA, mm=0), br_en -> pc=0x0040. IR=0x5200_FFFE (BRR) with pc=0x0010 and stat=0x2 -> pc=0x000E. IR=0x6200_0080 (BNE) with stat=0x2 -> pc unchanged. Same IR with stat=0 -> pc=0x0080.
- Simultaneous br_en + fetch_go in IDLE with taken BRA to 0x0020 -> imem_addr=0x0020 at the next edge.
- Protocol errors: fetch_go during REQ -> seq_err=1, fetch completes normally. Ack while IDLE -> no IR change.
- HLT and reset mid-fetch: fetch returns 0xF000_0000 -> halted=1, next fetch_go produces no imem_req. Separately, assert rst_f low during REQ -> imem_req=0 immediately, pc=RESET_PC, halted=0, seq_err=0.

Source files
------------

// File: rtl/sisc_ifetch.sv
// sisc_ifetch: instruction-fetch stage of the SISC computer.
// Holds PC and IR, fetches over a req/ack handshake, resolves branches.
module sisc_ifetch #(
  parameter int             AW       = 16,
  parameter int             DW       = 32,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          fetch_go,
  input  logic          br_en,
  input  logic [3:0]    stat,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_data,
  input  logic          imem_ack,
  output logic [DW-1:0] ir,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [AW-1:0] pc,
  output logic          ir_valid,
  output logic          halted,
  output logic          seq_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          req_q, req_d;
  logic          irv_q, irv_d;
  logic          halted_q, halted_d;
  logic          seq_err_q, seq_err_d;

  logic [3:0]    opc;
  logic [3:0]    mmf;
  logic [31:0]   imm_zx;
  logic [31:0]   imm_sx;
  logic [AW-1:0] tgt_abs;
  logic [AW-1:0] tgt_rel;
  logic          cond_any;
  logic          cond_none;
  logic          is_bra;
  logic          is_brr;
  logic          is_bne;

  assign opc       = ir_q[31:28];
  assign mmf       = ir_q[27:24];
  assign imm_zx    = {16'h0000, ir_q[15:0]};
  assign imm_sx    = {{16{ir_q[15]}}, ir_q[15:0]};
  assign tgt_abs   = imm_zx[AW-1:0];
  assign tgt_rel   = pc_q + imm_sx[AW-1:0];
  assign cond_none = ~|(mmf & stat);
  assign cond_any  = (mmf == 4'h0) || !cond_none;
  assign is_bra    = (opc == 4'd4);
  assign is_brr    = (opc == 4'd5);
  assign is_bne    = (opc == 4'd6);

  // Next-state: fetch sequencing, branch resolution, sticky flags
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    req_d     = req_q;
    irv_d     = 1'b0;
    halted_d  = halted_q;
    seq_err_d = seq_err_q;
    unique case (state_q)
      IDLE: begin
        if (br_en) begin
          unique case (1'b1)
            is_bra:  if (cond_any)  pc_d = tgt_abs;
            is_brr:  if (cond_any)  pc_d = tgt_rel;
            is_bne:  if (cond_none) pc_d = tgt_abs;
            default: pc_d = pc_q;
          endcase
        end
        if (fetch_go && !halted_q) begin
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (fetch_go || br_en) seq_err_d = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + AW'(1);
          req_d   = 1'b0;
          irv_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (fetch_go || br_en) seq_err_d = 1'b1;
        if (opc == 4'hF) halted_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset to a NOOP in IR
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      req_q     <= 1'b0;
      irv_q     <= 1'b0;
      halted_q  <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      req_q     <= req_d;
      irv_q     <= irv_d;
      halted_q  <= halted_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign opcode    = ir_q[31:28];
  assign mm        = ir_q[27:24];
  assign pc        = pc_q;
  assign ir_valid  = irv_q;
  assign halted    = halted_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_sisc_ifetch.sv
// tb_sisc_ifetch: scoreboard bench for sisc_ifetch.
// Directed fetches push expectations; a monitor pops on ir_valid.
module tb_sisc_ifetch;

  logic        clk;
  logic        rst_f;
  logic        fetch_go;
  logic        br_en;
  logic [3:0]  stat;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_ack;
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] pc;
  logic        ir_valid;
  logic        halted;
  logic        seq_err;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [15:0] pc;
    int          reqs;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;
  int   rq_cnt;
  logic [15:0] cap_addr;

  sisc_ifetch #(
    .AW(16),
    .DW(32),
    .RESET_PC(16'h0000)
  ) dut (
    .clk(clk),
    .rst_f(rst_f),
    .fetch_go(fetch_go),
    .br_en(br_en),
    .stat(stat),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .imem_ack(imem_ack),
    .ir(ir),
    .opcode(opcode),
    .mm(mm),
    .pc(pc),
    .ir_valid(ir_valid),
    .halted(halted),
    .seq_err(seq_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: track request cycles, pop and compare on each ir_valid
  always @(negedge clk) begin
    exp_t e;
    if (!rst_f) begin
      rq_cnt = 0;
    end else begin
      if (imem_req) begin
        if (rq_cnt == 0) cap_addr = imem_addr;
        else if (imem_addr !== cap_addr)
          chk("addr_stable", {16'h0, imem_addr}, {16'h0, cap_addr});
        rq_cnt++;
      end
      if (ir_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_ir_valid", {31'h0, ir_valid}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("ir", ir, e.data);
          chk("pc", {16'h0, pc}, {16'h0, e.pc});
          chk("opcode", {28'h0, opcode}, {28'h0, e.data[31:28]});
          chk("mm", {28'h0, mm}, {28'h0, e.data[27:24]});
          chk("req_addr", {16'h0, cap_addr}, {16'h0, e.addr});
          chk("req_cycles", rq_cnt, e.reqs);
        end
        rq_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] data, input int waits,
                          input logic br, input logic dup,
                          input logic [15:0] addr,
                          input logic [15:0] npc);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.pc   = npc;
    e.reqs = 1 + waits;
    sb.push_back(e);
    fetch_go = 1'b1;
    br_en    = br;
    step();
    fetch_go = 1'b0;
    br_en    = 1'b0;
    for (int w = 0; w < waits; w++) begin
      if (dup && w == 0) fetch_go = 1'b1;
      step();
      fetch_go = 1'b0;
    end
    imem_ack  = 1'b1;
    imem_data = data;
    step();
    imem_ack  = 1'b0;
    imem_data = '0;
    step();
  endtask

  task automatic branch(input logic [3:0] st, input logic [15:0] exp_pc,
                        input string nm);
    stat  = st;
    br_en = 1'b1;
    step();
    br_en = 1'b0;
    chk(nm, {16'h0, pc}, {16'h0, exp_pc});
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rq_cnt    = 0;
    cap_addr  = '0;
    rst_f     = 1'b0;
    fetch_go  = 1'b0;
    br_en     = 1'b0;
    stat      = 4'h0;
    imem_data = '0;
    imem_ack  = 1'b0;
    #12;
    chk("rst_pc", {16'h0, pc}, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_irv", {31'h0, ir_valid}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_seq_err", {31'h0, seq_err}, 32'h0);
    step();
    rst_f = 1'b1;
    step();

    do_fetch(32'h8123_0000, 0, 1'b0, 1'b0, 16'h0000, 16'h0001);
    do_fetch(32'h1111_2222, 3, 1'b0, 1'b0, 16'h0001, 16'h0002);

    do_fetch(32'h4000_0040, 0, 1'b0, 1'b0, 16'h0002, 16'h0003);
    branch(4'h0, 16'h0040, "bra_mm0");
    do_fetch(32'h4000_000F, 0, 1'b0, 1'b0, 16'h0040, 16'h0041);
    branch(4'h0, 16'h000F, "bra_to_0f");
    do_fetch(32'h5200_FFFE, 0, 1'b0, 1'b0, 16'h000F, 16'h0010);
    branch(4'h2, 16'h000E, "brr_back2");
    do_fetch(32'h6200_0080, 0, 1'b0, 1'b0, 16'h000E, 16'h000F);
    branch(4'h2, 16'h000F, "bne_not_taken");
    branch(4'h0, 16'h0080, "bne_taken");
    do_fetch(32'h1111_2222, 0, 1'b0, 1'b0, 16'h0080, 16'h0081);
    branch(4'hF, 16'h0081, "br_non_branch");
    chk("no_seq_err", {31'h0, seq_err}, 32'h0);

    do_fetch(32'h4000_0020, 0, 1'b0, 1'b0, 16'h0081, 16'h0082);
    do_fetch(32'h7000_0000, 0, 1'b1, 1'b0, 16'h0020, 16'h0021);

    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    step();
    imem_ack  = 1'b0;
    imem_data = '0;
    chk("idle_ack_ir", ir, 32'h7000_0000);
    chk("idle_ack_pc", {16'h0, pc}, 32'h0021);

    do_fetch(32'h2000_0001, 1, 1'b0, 1'b1, 16'h0021, 16'h0022);
    chk("seq_err_set", {31'h0, seq_err}, 32'h1);

    do_fetch(32'hF000_0000, 0, 1'b0, 1'b0, 16'h0022, 16'h0023);
    chk("halted_set", {31'h0, halted}, 32'h1);
    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
    chk("halt_no_req", {31'h0, imem_req}, 32'h0);
    step();
    step();
    chk("halt_no_req2", {31'h0, imem_req}, 32'h0);
    chk("halt_pc", {16'h0, pc}, 32'h0023);
    chk("halt_no_err", {31'h0, seq_err}, 32'h1);

    rst_f = 1'b0;
    #1;
    chk("rst2_halted", {31'h0, halted}, 32'h0);
    chk("rst2_seq_err", {31'h0, seq_err}, 32'h0);
    step();
    rst_f = 1'b1;
    step();

    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
    chk("mid_req", {31'h0, imem_req}, 32'h1);
    #2;
    rst_f = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
    chk("mid_rst_pc", {16'h0, pc}, 32'h0);
    chk("mid_rst_halted", {31'h0, halted}, 32'h0);
    chk("mid_rst_seq_err", {31'h0, seq_err}, 32'h0);
    step();
    rst_f = 1'b1;
    imem_ack  = 1'b1;
    imem_data = 32'h9999_9999;
    step();
    imem_ack  = 1'b0;
    imem_data = '0;
    chk("stale_ack_ir", ir, 32'h0);
    chk("stale_ack_pc", {16'h0, pc}, 32'h0);
    chk("stale_ack_req", {31'h0, imem_req}, 32'h0);

    do_fetch(32'h3000_0005, 0, 1'b0, 1'b0, 16'h0000, 16'h0001);
    step();
    step();
    chk("sb_empty", sb.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
